// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-requester round-robin arbiter in front of one shared FPU core
// Optional WAIT_DONE watchdog is compiled in when FPU_ARB_TIMEOUT_EN is defined.
module fpu_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        req0_start,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_done,
    output logic [31:0] req0_result,
    output logic        req0_err,
    input  logic        req1_start,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_done,
    output logic [31:0] req1_result,
    output logic        req1_err,
    output logic        fpu_start,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    input  logic        fpu_done,
    input  logic [31:0] fpu_result,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        WAIT_CORE_LOW,
        RESPOND
    } state_t;

    localparam logic [3:0] OP_INVALID = 4'hF;

    state_t           state_q, state_d;
    logic             fpu_start_q, fpu_start_d;
    logic [3:0]       fpu_op_q, fpu_op_d;
    logic [31:0]      fpu_a_q, fpu_a_d;
    logic [31:0]      fpu_b_q, fpu_b_d;
    logic [1:0]       done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic [1:0][31:0] result_q, result_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;

    logic [1:0]       start_vec;
    logic             grant;
    logic [3:0]       grant_op;
    logic [31:0]      grant_a;
    logic [31:0]      grant_b;

`ifdef FPU_ARB_TIMEOUT_EN
    logic [31:0]      tmo_cnt_q, tmo_cnt_d;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TIMEOUT_CYCLES - 32'd1);
`endif

    // On a tie the requester that was not served last wins.
    assign start_vec = {req1_start, req0_start};
    assign grant     = (start_vec == 2'b11) ? ~last_grant_q : start_vec[1];
    assign grant_op  = grant ? req1_op : req0_op;
    assign grant_a   = grant ? req1_a  : req0_a;
    assign grant_b   = grant ? req1_b  : req0_b;

    always_comb begin
        state_d      = state_q;
        fpu_start_d  = fpu_start_q;
        fpu_op_d     = fpu_op_q;
        fpu_a_d      = fpu_a_q;
        fpu_b_d      = fpu_b_q;
        done_d       = done_q;
        err_d        = err_q;
        result_d     = result_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
`ifdef FPU_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_vec != 2'b00) begin
                    owner_d  = grant;
                    fpu_op_d = grant_op;
                    fpu_a_d  = grant_a;
                    fpu_b_d  = grant_b;
                    if (grant_op == OP_INVALID) begin
                        result_d[grant] = '0;
                        err_d[grant]    = 1'b1;
                        done_d[grant]   = 1'b1;
                        state_d         = RESPOND;
                    end else begin
                        fpu_start_d = 1'b1;
                        state_d     = WAIT_DONE;
`ifdef FPU_ARB_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end
            end
            WAIT_DONE: begin
                if (fpu_done) begin
                    result_d[owner_q] = fpu_result;
                    err_d[owner_q]    = 1'b0;
                    fpu_start_d       = 1'b0;
                    state_d           = WAIT_CORE_LOW;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    result_d[owner_q] = '0;
                    err_d[owner_q]    = 1'b1;
                    fpu_start_d       = 1'b0;
                    state_d           = WAIT_CORE_LOW;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                end
`endif
            end
            // Handshake with the core completes before the requester sees done.
            WAIT_CORE_LOW: begin
                if (!fpu_done) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = RESPOND;
                end
            end
            RESPOND: begin
                if (!start_vec[owner_q]) begin
                    done_d[owner_q] = 1'b0;
                    err_d[owner_q]  = 1'b0;
                    last_grant_d    = owner_q;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= IDLE;
            fpu_start_q  <= 1'b0;
            fpu_op_q     <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            done_q       <= '0;
            err_q        <= '0;
            result_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fpu_start_q  <= fpu_start_d;
            fpu_op_q     <= fpu_op_d;
            fpu_a_q      <= fpu_a_d;
            fpu_b_q      <= fpu_b_d;
            done_q       <= done_d;
            err_q        <= err_d;
            result_q     <= result_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
`ifdef FPU_ARB_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign fpu_start   = fpu_start_q;
    assign fpu_op      = fpu_op_q;
    assign fpu_a       = fpu_a_q;
    assign fpu_b       = fpu_b_q;
    assign req0_done   = done_q[0];
    assign req1_done   = done_q[1];
    assign req0_err    = err_q[0];
    assign req1_err    = err_q[1];
    assign req0_result = result_q[0];
    assign req1_result = result_q[1];
    assign busy        = (state_q != IDLE);
    assign owner       = owner_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - randomized self-checking bench for fpu_arbiter against a reference model
`timescale 1ns/1ps
module tb_fpu_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [3:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        r_done0, r_done1, r_err0, r_err1;
    logic [31:0] r_res0, r_res1;
    logic        fpu_start, busy, owner;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b;
    logic        fpu_done = 1'b0;
    logic [31:0] fpu_result = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_last = 1'b1;

    int          core_lat = 3;
    int          core_cnt = 0;
    bit          core_mute = 1'b0;
    bit          core_force = 1'b0;
    logic [31:0] core_force_val = '0;

    fpu_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .arst_n(arst_n),
        .req0_start(start[0]), .req0_op(op[0]), .req0_a(a[0]), .req0_b(b[0]),
        .req0_done(r_done0), .req0_result(r_res0), .req0_err(r_err0),
        .req1_start(start[1]), .req1_op(op[1]), .req1_a(a[1]), .req1_b(b[1]),
        .req1_done(r_done1), .req1_result(r_res1), .req1_err(r_err1),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
        .fpu_done(fpu_done), .fpu_result(fpu_result),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] core_fn(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        return (x + y) ^ {o, 28'h0};
    endfunction

    function automatic logic [31:0] exp_res(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        return (o == 4'hF) ? 32'h0 : core_fn(o, x, y);
    endfunction

    function automatic logic done_of(input int n);
        return (n == 1) ? r_done1 : r_done0;
    endfunction

    function automatic logic err_of(input int n);
        return (n == 1) ? r_err1 : r_err0;
    endfunction

    function automatic logic [31:0] res_of(input int n);
        return (n == 1) ? r_res1 : r_res0;
    endfunction

    // Mock FPU core: answers core_lat cycles after start, holds done until start drops.
    always @(negedge clk) begin
        if (!fpu_start) begin
            core_cnt = 0;
            fpu_done = 1'b0;
        end else if (!core_mute && !fpu_done) begin
            core_cnt++;
            if (core_cnt >= core_lat) begin
                fpu_done   = 1'b1;
                fpu_result = core_force ? core_force_val : core_fn(fpu_op, fpu_a, fpu_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        start  = 2'b00;
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic serve(input bit en0, input bit en1, input bit scramble);
        logic [3:0]  xo [2];
        logic [31:0] xa [2];
        logic [31:0] xb [2];
        bit          got [2];
        bit          first, cur;
        bit          scr;
        scr = 1'b0;
        got[0] = 1'b0;
        got[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            xo[n] = 4'($urandom_range(0, 15));
            xa[n] = $urandom;
            xb[n] = $urandom;
            op[n] = xo[n];
            a[n]  = xa[n];
            b[n]  = xb[n];
        end
        first = (en0 && en1) ? !m_last : en1;
        cur   = first;
        start = {en1, en0};
        for (int c = 0; c < 400 && (start != 2'b00 || busy); c++) begin
            @(negedge clk);
            if (busy) chk("owner", 32'(owner), 32'(cur));
            if (fpu_start) begin
                chk("fpu_op", 32'(fpu_op), 32'(xo[cur]));
                chk("fpu_a", fpu_a, xa[cur]);
                chk("fpu_b", fpu_b, xb[cur]);
                if (scramble && !scr) begin
                    op[cur] = 4'($urandom);
                    a[cur]  = $urandom;
                    b[cur]  = $urandom;
                    scr     = 1'b1;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (start[n] && done_of(n)) begin
                    chk("done_owner", 32'(n), 32'(cur));
                    chk("result", res_of(n), exp_res(xo[n], xa[n], xb[n]));
                    chk("err", 32'(err_of(n)), 32'(xo[n] == 4'hF));
                    chk("other_done", 32'(done_of(1 - n)), 32'(0));
                    start[n] = 1'b0;
                    got[n]   = 1'b1;
                    m_last   = n[0];
                    if (en0 && en1) cur = !cur;
                end
            end
        end
        chk("served", 32'({got[1], got[0]}), 32'({en1, en0}));
    endtask

    initial begin
        int lat;
        int pulses;
        int c0;
        for (int n = 0; n < 2; n++) begin
            op[n] = '0;
            a[n]  = '0;
            b[n]  = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_fpu_start", 32'(fpu_start), 32'(0));
        chk("rst_done", 32'({r_done1, r_done0}), 32'(0));
        chk("rst_err", 32'({r_err1, r_err0}), 32'(0));
        chk("rst_res0", r_res0, 32'h0);
        chk("rst_res1", r_res1, 32'h0);
        chk("rst_owner", 32'(owner), 32'(0));
        chk("rst_fpu_ab", fpu_a | fpu_b | 32'(fpu_op), 32'h0);
        arst_n = 1'b1;

        // Single add with a 5-cycle core
        @(negedge clk);
        core_force = 1'b1;
        core_force_val = 32'h40400000;
        core_lat = 5;
        op[0] = 4'h0;
        a[0] = 32'h3F800000;
        b[0] = 32'h40000000;
        start[0] = 1'b1;
        chk("add_start_pre", 32'(fpu_start), 32'(0));
        @(negedge clk);
        chk("add_start_rise", 32'(fpu_start), 32'(1));
        chk("add_fpu_a", fpu_a, 32'h3F800000);
        chk("add_fpu_b", fpu_b, 32'h40000000);
        chk("add_busy", 32'(busy), 32'(1));
        lat = 1;
        while (!r_done0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("add_latency", 32'(lat), 32'(7));
        chk("add_result", r_res0, 32'h40400000);
        chk("add_err", 32'(r_err0), 32'(0));
        start[0] = 1'b0;
        @(negedge clk);
        chk("add_idle", 32'({busy, r_done0}), 32'(0));
        m_last = 1'b0;
        core_force = 1'b0;
        core_lat = 3;

        // Ties after reset, then round-robin alternation
        do_reset();
        serve(1'b1, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 1'b0);
        serve(1'b1, 1'b1, 1'b0);

        // Invalid opcode answered without touching the core
        @(negedge clk);
        op[1] = 4'hF;
        a[1] = $urandom;
        b[1] = $urandom;
        start[1] = 1'b1;
        @(negedge clk);
        chk("inv_done", 32'(r_done1), 32'(1));
        chk("inv_err", 32'(r_err1), 32'(1));
        chk("inv_result", r_res1, 32'h0);
        chk("inv_fpu_start", 32'(fpu_start), 32'(0));
        chk("inv_owner", 32'(owner), 32'(1));
        start[1] = 1'b0;
        @(negedge clk);
        chk("inv_clear", 32'({busy, r_err1, r_done1}), 32'(0));
        m_last = 1'b1;

        // Asynchronous reset while waiting on the core
        core_mute = 1'b1;
        op[0] = 4'h2;
        start[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_pre_start", 32'(fpu_start), 32'(1));
        #2 arst_n = 1'b0;
        #1;
        chk("ar_fpu_start", 32'(fpu_start), 32'(0));
        chk("ar_busy", 32'(busy), 32'(0));
        chk("ar_done", 32'({r_done1, r_done0}), 32'(0));
        start[0] = 1'b0;
        m_last = 1'b1;
        @(negedge clk);
        arst_n = 1'b1;
        core_mute = 1'b0;
        serve(1'b1, 1'b0, 1'b1);

        // Owner withdraws during WAIT_DONE while req1 waits
        @(negedge clk);
        core_lat = 4;
        op[0] = 4'($urandom_range(0, 14));
        a[0] = $urandom;
        b[0] = $urandom;
        start[0] = 1'b1;
        @(negedge clk);
        op[1] = 4'($urandom_range(0, 14));
        a[1] = $urandom;
        b[1] = $urandom;
        start[1] = 1'b1;
        chk("wd_start", 32'(fpu_start), 32'(1));
        start[0] = 1'b0;
        pulses = 0;
        c0 = -10;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (r_done0) begin
                if (pulses == 0) begin
                    chk("wd_res0", r_res0, core_fn(op[0], a[0], b[0]));
                    chk("wd_err0", 32'(r_err0), 32'(0));
                    c0 = c;
                end
                pulses++;
            end
            if (c == c0 + 2) chk("wd_next_grant", 32'({busy, owner}), 32'(3));
            if (r_done1) begin
                chk("wd_res1", r_res1, core_fn(op[1], a[1], b[1]));
                break;
            end
        end
        chk("wd_pulse", 32'(pulses), 32'(1));
        chk("wd_done1", 32'(r_done1), 32'(1));
        start[1] = 1'b0;
        @(negedge clk);
        m_last = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 30; i++) begin
            int en;
            en = $urandom_range(1, 3);
            core_lat = $urandom_range(1, 6);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            serve(en[0], en[1], 1'($urandom));
        end

`ifdef FPU_ARB_TIMEOUT_EN
        // Core that never answers
        @(negedge clk);
        core_mute = 1'b1;
        op[0] = 4'h1;
        start[0] = 1'b1;
        lat = 0;
        for (int c = 0; c < 100 && !r_done0; c++) begin
            @(negedge clk);
            if (fpu_start) lat++;
        end
        chk("tmo_cycles", 32'(lat), 32'(TMO));
        chk("tmo_done", 32'(r_done0), 32'(1));
        chk("tmo_err", 32'(r_err0), 32'(1));
        chk("tmo_result", r_res0, 32'h0);
        start[0] = 1'b0;
        core_mute = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
